// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one SRT mantissa divider between NREQ requesters.
// Zero divisors are answered directly; a hung divider is cut off by a timeout.
module div_arbiter #(
    parameter int unsigned WIDTH   = 24,
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TAGW    = 4,
    parameter int unsigned TIMEOUT = 31
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WIDTH-1:0]  req_divisor,
    input  logic [NREQ*WIDTH-1:0]  req_dividend,
    input  logic [NREQ*TAGW-1:0]   req_tag,
    output logic [NREQ-1:0]        resp_valid,
    input  logic [NREQ-1:0]        resp_ready,
    output logic [WIDTH-1:0]       resp_result,
    output logic [TAGW-1:0]        resp_tag,
    output logic [1:0]             resp_err,
    output logic                   div_start,
    output logic [WIDTH-1:0]       div_divisor,
    output logic [WIDTH-1:0]       div_dividend,
    input  logic [WIDTH-1:0]       div_result,
    input  logic                   div_done,
    output logic                   busy
);

    localparam int unsigned IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [5:0]  TO_LAST = 6'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t            state, state_n;
    logic [IW-1:0]     rr_ptr, gidx, gnt_idx;
    logic              gnt_found;
    logic              accept;
    logic              timeout;
    logic [5:0]        tcnt;
    logic [WIDTH-1:0]  sel_divisor, sel_dividend;
    logic [TAGW-1:0]   sel_tag;

    function automatic logic [IW-1:0] wrap(input logic [31:0] v);
        return IW'(v % NREQ);
    endfunction

    // First valid requester at or after rr_ptr, scanning modulo NREQ
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!gnt_found && req_valid[wrap(32'(rr_ptr) + k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap(32'(rr_ptr) + k);
            end
        end
    end

    assign sel_divisor  = req_divisor[gnt_idx*WIDTH +: WIDTH];
    assign sel_dividend = req_dividend[gnt_idx*WIDTH +: WIDTH];
    assign sel_tag      = req_tag[gnt_idx*TAGW +: TAGW];
    assign accept       = (state == IDLE) && gnt_found && !reset;
    assign timeout      = (tcnt == TO_LAST);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // req_ready is masked by reset so every output reads 0 while reset is held
    always_comb begin
        state_n    = state;
        req_ready  = '0;
        resp_valid = '0;
        div_start  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_ready[gnt_idx] = 1'b1;
                    state_n = (sel_divisor == '0) ? RESP : START;
                end
            end
            START: begin
                div_start = 1'b1;
                state_n   = WAIT;
            end
            WAIT: begin
                if (div_done || timeout) state_n = RESP;
            end
            RESP: begin
                resp_valid[gidx] = 1'b1;
                if (resp_ready[gidx]) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr       <= '0;
            gidx         <= '0;
            tcnt         <= '0;
            div_divisor  <= '0;
            div_dividend <= '0;
            resp_result  <= '0;
            resp_tag     <= '0;
            resp_err     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        gidx         <= gnt_idx;
                        div_divisor  <= sel_divisor;
                        div_dividend <= sel_dividend;
                        resp_tag     <= sel_tag;
                        if (sel_divisor == '0) begin
                            resp_result <= '1;
                            resp_err    <= 2'b01;
                        end
                    end
                end
                START: tcnt <= '0;
                WAIT: begin
                    if (div_done) begin
                        resp_result <= div_result;
                        resp_err    <= 2'b00;
                    end else if (timeout) begin
                        resp_result <= '0;
                        resp_err    <= 2'b10;
                    end else begin
                        tcnt <= tcnt + 6'd1;
                    end
                end
                RESP: begin
                    if (resp_ready[gidx]) rr_ptr <= wrap(32'(gidx) + 32'd1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural divider stub
// (done level rises 12 cycles after the start edge unless told to hang).
module tb_div_arbiter;

    localparam int W = 24;
    localparam int N = 2;
    localparam int T = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_divisor = '0;
    logic [N*W-1:0]   req_dividend = '0;
    logic [N*T-1:0]   req_tag = '0;
    logic [N-1:0]     resp_valid;
    logic [N-1:0]     resp_ready = '0;
    logic [W-1:0]     resp_result;
    logic [T-1:0]     resp_tag;
    logic [1:0]       resp_err;
    logic             div_start;
    logic [W-1:0]     div_divisor;
    logic [W-1:0]     div_dividend;
    logic [W-1:0]     div_result;
    logic             div_done = 1'b0;
    logic             busy;

    logic [W-1:0]     stub_result = '0;
    bit               stub_hang = 1'b0;
    int               stub_cnt = 0;
    int               start_cnt = 0;
    int               total = 0;
    int               bad = 0;

    div_arbiter #(.WIDTH(W), .NREQ(N), .TAGW(T), .TIMEOUT(31)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_divisor(req_divisor), .req_dividend(req_dividend), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_tag(resp_tag), .resp_err(resp_err),
        .div_start(div_start), .div_divisor(div_divisor), .div_dividend(div_dividend),
        .div_result(div_result), .div_done(div_done), .busy(busy)
    );

    always #5 clk = ~clk;

    assign div_result = stub_result;

    always @(posedge clk) begin
        if (div_start) begin
            start_cnt <= start_cnt + 1;
            div_done  <= 1'b0;
            stub_cnt  <= stub_hang ? 0 : 12;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) div_done <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                           input logic [T-1:0] tag);
        req_dividend[i*W +: W] = dvd;
        req_divisor[i*W +: W]  = dvs;
        req_tag[i*T +: T]      = tag;
        req_valid[i]           = 1'b1;
    endtask

    // Called just after a negedge; returns at the negedge following the accept edge
    task automatic accept(input int i);
        int n;
        n = 0;
        #1;
        while (req_ready == '0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("req_ready_grant", 32'(req_ready), 32'(1 << i));
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_resp(input int maxc, output int n);
        n = 0;
        while (resp_valid == '0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("resp_arrives", 32'(resp_valid != '0), 32'd1);
    endtask

    task automatic handshake(input int i);
        resp_ready[i] = 1'b1;
        @(posedge clk);
        #1 resp_ready = '0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int s0;
        int hold_bad;
        int rdy_bad;
        int spur;

        // Reset values
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_div_start", 32'(div_start), 0);
        chk("rst_resp_err", 32'(resp_err), 0);
        chk("rst_resp_result", 32'(resp_result), 0);
        chk("rst_resp_tag", 32'(resp_tag), 0);
        chk("rst_div_divisor", 32'(div_divisor), 0);
        reset = 1'b0;

        // Single request
        set_req(0, 24'h600000, 24'h400000, 4'd5);
        stub_result = 24'h123456;
        s0 = start_cnt;
        accept(0);
        chk("single_div_start", 32'(div_start), 1);
        chk("single_divisor", 32'(div_divisor), 32'h400000);
        chk("single_dividend", 32'(div_dividend), 32'h600000);
        wait_resp(20, n);
        chk("single_valid", 32'(resp_valid), 32'b01);
        chk("single_result", 32'(resp_result), 32'h123456);
        chk("single_tag", 32'(resp_tag), 5);
        chk("single_err", 32'(resp_err), 0);
        chk("single_starts", 32'(start_cnt - s0), 1);
        handshake(0);
        chk("single_busy_after", 32'(busy), 0);

        // Contention from reset release
        reset = 1'b1;
        set_req(0, 24'h000010, 24'h000002, 4'd1);
        set_req(1, 24'h000300, 24'h000003, 4'd2);
        #1 chk("cont_ready_in_reset", 32'(req_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        stub_result = 24'h000008;
        accept(0);
        wait_resp(20, n);
        chk("cont0_valid", 32'(resp_valid), 32'b01);
        chk("cont0_result", 32'(resp_result), 32'h8);
        chk("cont0_tag", 32'(resp_tag), 1);
        set_req(0, 24'h000900, 24'h000003, 4'd7);
        handshake(0);
        stub_result = 24'h000100;
        accept(1);
        set_req(1, 24'h000050, 24'h000005, 4'd9);
        wait_resp(20, n);
        chk("cont1_valid", 32'(resp_valid), 32'b10);
        chk("cont1_result", 32'(resp_result), 32'h100);
        chk("cont1_tag", 32'(resp_tag), 2);
        handshake(1);
        stub_result = 24'h000300;
        accept(0);
        chk("wrap_divisor", 32'(div_divisor), 32'h3);
        wait_resp(20, n);
        chk("wrap_valid", 32'(resp_valid), 32'b01);
        chk("wrap_result", 32'(resp_result), 32'h300);
        chk("wrap_tag", 32'(resp_tag), 7);

        // Backpressure with requester 1 waiting
        hold_bad = 0;
        rdy_bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (resp_valid !== 2'b01 || resp_result !== 24'h000300 ||
                resp_tag !== 4'd7 || resp_err !== 2'b00) hold_bad++;
            if (req_ready !== 2'b00) rdy_bad++;
        end
        chk("hold_resp_stable", 32'(hold_bad), 0);
        chk("hold_req_ready_low", 32'(rdy_bad), 0);
        handshake(0);
        #1 chk("ready1_after_hs", 32'(req_ready), 32'b10);
        stub_result = 24'h00000A;
        accept(1);
        wait_resp(20, n);
        chk("bp1_result", 32'(resp_result), 32'hA);
        chk("bp1_tag", 32'(resp_tag), 9);
        handshake(1);

        // Zero divisor
        set_req(0, 24'h111111, 24'h000000, 4'd3);
        s0 = start_cnt;
        accept(0);
        chk("zero_valid_next", 32'(resp_valid), 32'b01);
        chk("zero_result", 32'(resp_result), 32'hFFFFFF);
        chk("zero_err", 32'(resp_err), 1);
        chk("zero_tag", 32'(resp_tag), 3);
        chk("zero_no_div_start", 32'(div_start), 0);
        handshake(0);
        chk("zero_starts", 32'(start_cnt - s0), 0);

        // Hung divider
        stub_hang = 1'b1;
        set_req(1, 24'h222222, 24'h000007, 4'hC);
        accept(1);
        wait_resp(40, n);
        chk("hang_cycles", 32'(n), 32);
        chk("hang_valid", 32'(resp_valid), 32'b10);
        chk("hang_err", 32'(resp_err), 2);
        chk("hang_result", 32'(resp_result), 0);
        chk("hang_tag", 32'(resp_tag), 32'hC);
        handshake(1);
        stub_hang = 1'b0;
        set_req(0, 24'h000040, 24'h000008, 4'd6);
        stub_result = 24'h000008;
        accept(0);
        wait_resp(20, n);
        chk("after_hang_result", 32'(resp_result), 32'h8);
        chk("after_hang_err", 32'(resp_err), 0);
        chk("after_hang_tag", 32'(resp_tag), 6);
        handshake(0);

        // Reset mid-WAIT, then a stale done level
        set_req(1, 24'h333333, 24'h000011, 4'hE);
        stub_result = 24'h0BAD00;
        accept(1);
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_resp_valid", 32'(resp_valid), 0);
        chk("mid_rst_req_ready", 32'(req_ready), 0);
        chk("mid_rst_div_divisor", 32'(div_divisor), 0);
        chk("mid_rst_div_dividend", 32'(div_dividend), 0);
        chk("mid_rst_resp_result", 32'(resp_result), 0);
        chk("mid_rst_resp_tag", 32'(resp_tag), 0);
        @(negedge clk);
        reset = 1'b0;
        spur = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (resp_valid !== 2'b00 || busy !== 1'b0) spur++;
        end
        chk("stale_done_ignored", 32'(spur), 0);
        stub_result = 24'h0F0F0F;
        set_req(1, 24'h444444, 24'h000002, 4'hB);
        accept(1);
        wait_resp(20, n);
        chk("post_rst_valid", 32'(resp_valid), 32'b10);
        chk("post_rst_result", 32'(resp_result), 32'h0F0F0F);
        chk("post_rst_tag", 32'(resp_tag), 32'hB);
        chk("post_rst_err", 32'(resp_err), 0);
        handshake(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one radix-4 SRT mantissa divider (24-bit operands, one start pulse, level done) between NREQ requesters, e.g. the FPU FDIV path and the reciprocal/rsqrt seed path.
- Arbitrates round-robin, latches operands, pulses the divider start and waits for its done level.
- Returns the quotient with the requester's tag over a valid/ready response channel.
- Short-circuits zero divisors and guards against a hung divider with a timeout.

Parameters:
WIDTH, 24, operand/result width (divider SIZE+1)
NREQ, 2, number of requesters (2..8)
TAGW, 4, request tag width
TIMEOUT, 31, max cycles in WAIT before error response (fits 6-bit counter)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  one-hot accept, one cycle
req_divisor  in  NREQ*WIDTH  packed divisors, requester i at [i*WIDTH +: WIDTH]
req_dividend  in  NREQ*WIDTH  packed dividends
req_tag  in  NREQ*TAGW  packed tags
resp_valid  out  NREQ  one-hot response valid to the granted requester
resp_ready  in  NREQ  per-requester response accept
resp_result  out  WIDTH  quotient
resp_tag  out  TAGW  tag of the request being answered
resp_err  out  2  00 ok, 01 divide-by-zero, 10 timeout
div_start  out  1  one-cycle start pulse to the divider
div_divisor  out  WIDTH  registered divisor, stable from START until IDLE
div_dividend  out  WIDTH  registered dividend, stable from START until IDLE
div_result  in  WIDTH  divider quotient (qpos - qneg)
div_done  in  1  divider done level; forced low the edge after start
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE, rr_ptr=0, all outputs 0 (req_ready, resp_valid, div_start, busy, resp_err, resp_result, resp_tag, div_divisor, div_dividend).
- Reset mid-operation aborts silently. The divider may keep iterating; this is harmless because the next start reloads it.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - If any req_valid, grant the first valid requester at or after rr_ptr, modulo NREQ.
  - req_ready[g] is high combinationally for that cycle only.
  - At the edge, latch divisor, dividend, tag and grant index.
  - If the latched divisor is 0: resp_result=all-ones, resp_err=01, go to RESP; the divider is not started.
  - Otherwise go to START.
- START: div_start=1 for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - First cycle with div_done=1: register div_result into resp_result, resp_err=00, go to RESP.
  - If the counter reaches TIMEOUT first: resp_result=0, resp_err=10, go to RESP.
  - div_done is never sampled in IDLE or START; a stale done from a previous run must not complete a new one.
- RESP:
  - resp_valid[g]=1, all other bits 0. resp_result, resp_tag and resp_err are held stable until handshake.
  - On resp_ready[g]: rr_ptr = g+1 mod NREQ, go to IDLE.
  - resp_ready on non-granted lines is ignored.
- Throughput: at most one operation in flight. No new request is accepted until the cycle after a response handshake; IDLE must last at least one cycle.
- Latency with a 24-bit divider (done 12 cycles after the start edge): accept at T, start at T+1, resp_valid by T+15. Zero divisor: resp_valid at T+1.
- Simultaneous requests: only one is granted per IDLE cycle. A losing requester keeps req_valid high and is served next by rr order.
- Requesters must hold req_valid and operands until req_ready. Dropping req_valid early is legal only before any grant.
- NREQ=1 degenerates to a pass-through sequencer; rr_ptr stays 0.

Test Plan:
- Single request: requester 0, dividend 0x600000, divisor 0x400000, tag 5; bench divider stub raises done 12 cycles after start with result 0x123456. Required: exactly one div_start pulse, resp_valid=01, resp_result=0x123456, tag 5, err 00, busy low after handshake.
- Contention: both req_valid high at reset release. Required: requester 0 served first; then requester 1 with its own operands/tag; then requester 0 again (rr_ptr wrap).
- Zero divisor: divisor 0, tag 3. Required: no div_start; resp_valid next cycle; result 0xFFFFFF, err 01.
- Backpressure: hold resp_ready low 20 cycles. Required: response held stable; req_ready stays 0 for a waiting requester 1; req_ready[1] asserts the cycle after the handshake.
- Hung divider: stub never raises done. Required: after 31 WAIT cycles, resp_err=10, result 0; next request proceeds normally.
- Reset mid-WAIT: assert reset 6 cycles after start. Required: all outputs 0 immediately (asynchronous). After release, a stale div_done=1 from the old run does not produce a response; a new request completes correctly.
